mcpu_fetch_unit: RTL and testbench

//  Instruction fetch stage of the MCPU. Sits directly upstream of the RAM controller's

---
 rtl/mcpu_pkg.sv | 15 +
 rtl/mcpu_sync_fifo.sv | 68 ++++++
 rtl/mcpu_fetch_unit.sv | 104 ++++++++++
 tb/tb_mcpu_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU fetch path.
//  - fetch_state_e : fetch FSM states (idle after reset, fetching, halted)
//  - MCPU_WORD_SIZE / MCPU_ADDR_WIDTH : default instruction and address widths
package mcpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned MCPU_WORD_SIZE  = 8;
  localparam int unsigned MCPU_ADDR_WIDTH = 8;

endpackage

// File: rtl/mcpu_sync_fifo.sv
// Small synchronous FIFO with flush, used as the fetch prefetch buffer.
// Ports:
//  clk, rst_n  : clock, asynchronous active-low reset
//  flush_i     : drop all entries (has priority over push/pop)
//  push_i      : write wdata_i; caller guarantees room (or a same-cycle pop)
//  wdata_i     : entry to write
//  pop_i       : drop head; caller guarantees not empty
//  rdata_o     : head entry; while empty it holds the last value presented
//  count_o     : number of stored entries (0..DEPTH)
//  empty_o     : no entries stored
module mcpu_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // last_q tracks whatever was presented the cycle before, so an empty FIFO
  // keeps showing the previous head instead of a stale storage slot.
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      last_q <= rdata_o;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_i) begin
          mem_q[wr_ptr_q] <= wdata_i;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MCPU instruction fetch stage. Presents the PC to the RAM instruction port,
// captures the same-cycle read data into a prefetch FIFO and hands entries to
// decode.
// Handshake: an instruction transfers on a cycle where instr_valid & instr_ready
// are both high; while instr_valid is high and instr_ready low, instr, instr_pc
// and instr_valid do not change. A redirect overrides everything: the FIFO is
// flushed, no transfer happens that cycle, and fetch restarts at redirect_pc.
// Ports:
//  clk, rst_n           : clock, asynchronous active-low reset
//  instraddr / instrrd  : RAM instruction address out / read data in (same cycle)
//  instr_valid, instr,
//  instr_pc, instr_ready: decode interface (head of prefetch FIFO)
//  redirect, redirect_pc: taken branch, flush and restart at redirect_pc
//  halt_req, resume     : stop / restart fetching; buffered entries still drain
//  halted               : fetch FSM is in S_HALT
module mcpu_fetch_unit
  import mcpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = MCPU_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH = MCPU_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instraddr,
  input  logic [WORD_SIZE-1:0]  instrrd,
  output logic                  instr_valid,
  output logic [WORD_SIZE-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  halted
);

  localparam int unsigned EW = WORD_SIZE + ADDR_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_rdata;
  logic          flush, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (halt_req) state_d = S_HALT;
      S_HALT:  if (resume && !halt_req) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Redirect is ignored in S_IDLE (nothing fetched yet); elsewhere it wins.
  assign flush = redirect && (state_q != S_IDLE);
  assign pop   = !fifo_empty && instr_ready && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = (state_q == S_FETCH) && !redirect &&
                 ((fifo_count < CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    pc_d = pc_q;
    if (flush)     pc_d = redirect_pc;
    else if (push) pc_d = pc_q + ADDR_WIDTH'(1);
  end

  mcpu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({pc_q, instrrd}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign instraddr   = pc_q;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata[WORD_SIZE-1:0];
  assign instr_pc    = fifo_rdata[EW-1:WORD_SIZE];
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
module tb_mcpu_fetch_unit;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instraddr, instrrd, instr, instr_pc, redirect_pc;
  logic       instr_valid, instr_ready, redirect, halt_req, resume, halted;

  always #5 clk = ~clk;

  // Instruction RAM, combinational read: mem[i] = i ^ 0xA5
  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
  assign instrrd = ram[instraddr];

  mcpu_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instraddr   (instraddr),
    .instrrd     (instrrd),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .halted      (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of buffered {pc, instr}; the instruction for an address is the RAM rule.
  typedef struct packed { logic [7:0] pc; logic [7:0] ins; } ent_t;
  ent_t       mq[$];
  logic [7:0] m_pc;
  bit         m_started, m_halted, m_pop, m_push;
  int         m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc = 8'h00; m_started = 0; m_halted = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz > 0) && instr_ready;
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        m_push = !m_halted && (m_sz < 2 || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{pc: m_pc, ins: m_pc ^ 8'hA5});
          m_pc = m_pc + 8'd1;
        end
      end
      if (!m_halted && halt_req) m_halted = 1;
      else if (m_halted && resume && !halt_req) m_halted = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("model_valid", instr_valid, mq.size() > 0);
    chk("model_instraddr", instraddr, m_pc);
    chk("model_halted", halted, m_halted);
    if (mq.size() > 0) begin
      chk("model_instr_pc", instr_pc, mq[0].pc);
      chk("model_instr", instr, mq[0].ins);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset away from the sampling edge, release on a negedge.
  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic expect_head(input string name, input logic [7:0] pc, input logic [7:0] ins);
    chk({name, "_valid"}, instr_valid, 1'b1);
    chk({name, "_pc"}, instr_pc, pc);
    chk({name, "_instr"}, instr, ins);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] exp_pc [4];
  logic [7:0] exp_in [4];

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
    halt_req = 1'b0; resume = 1'b0;

    // Reset values
    cyc(2);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_pc", instr_pc, 8'h00);
    chk("rst_instraddr", instraddr, 8'h00);
    chk("rst_halted", halted, 1'b0);

    // Streaming from reset: idle cycle, then 0,1,2,3
    rst_n = 1'b1;
    cyc(1); chk("t1_idle_valid", instr_valid, 1'b0);
    exp_pc = '{8'h00, 8'h01, 8'h02, 8'h03};
    exp_in = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    for (int k = 0; k < 4; k++) begin
      cyc(1); expect_head("t1_stream", exp_pc[k], exp_in[k]);
    end

    // Back-pressure from reset: FIFO fills with 0,1; pc stops at 2
    instr_ready = 1'b0;
    do_reset();
    cyc(6);
    expect_head("t2_full", 8'h00, 8'hA5);
    chk("t2_pc_stop", instraddr, 8'h02);
    instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      cyc(1); expect_head("t2_drain", exp_pc[k], exp_in[k]);
    end

    // Redirect with a full FIFO
    instr_ready = 1'b0;
    cyc(3);
    redirect = 1'b1; redirect_pc = 8'h40;
    cyc(1);
    redirect = 1'b0; instr_ready = 1'b1;
    chk("t3_flush_valid", instr_valid, 1'b0);
    chk("t3_flush_addr", instraddr, 8'h40);
    cyc(1); expect_head("t3_first", 8'h40, 8'hE5);
    cyc(1); expect_head("t3_second", 8'h41, 8'hE4);

    // Redirect near the top of the address space: wrap 0xFF -> 0x00
    redirect = 1'b1; redirect_pc = 8'hFE;
    cyc(1);
    redirect = 1'b0;
    chk("t4_flush_valid", instr_valid, 1'b0);
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_in = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    for (int k = 0; k < 4; k++) begin
      cyc(1); expect_head("t4_wrap", exp_pc[k], exp_in[k]);
    end

    // Halt with two buffered entries, drain, resume from frozen pc
    instr_ready = 1'b0;
    do_reset();
    cyc(5);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0; instr_ready = 1'b1;
    chk("t5_halted", halted, 1'b1);
    expect_head("t5_drain0", 8'h00, 8'hA5);
    cyc(1); expect_head("t5_drain1", 8'h01, 8'hA4);
    cyc(1);
    chk("t5_empty", instr_valid, 1'b0);
    chk("t5_frozen", instraddr, 8'h02);
    cyc(2);
    chk("t5_still_halted", halted, 1'b1);
    chk("t5_still_frozen", instraddr, 8'h02);
    resume = 1'b1;
    cyc(1);
    resume = 1'b0;
    chk("t5_resumed", halted, 1'b0);
    chk("t5_resume_gap", instr_valid, 1'b0);
    cyc(1); expect_head("t5_restart", 8'h02, 8'hA7);

    // Redirect and halt together: flush, new pc, halted
    redirect = 1'b1; redirect_pc = 8'h80; halt_req = 1'b1;
    cyc(1);
    redirect = 1'b0; halt_req = 1'b0;
    chk("t6_halted", halted, 1'b1);
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_addr", instraddr, 8'h80);
    cyc(3);
    chk("t6_no_fetch", instr_valid, 1'b0);
    resume = 1'b1;
    cyc(1);
    resume = 1'b0;
    cyc(1); expect_head("t6_restart", 8'h80, 8'h25);

    // Asynchronous reset mid-stream with a full FIFO
    instr_ready = 1'b0;
    cyc(3);
    chk("t7_full_before", instr_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", instr_valid, 1'b0);
    chk("t7_async_addr", instraddr, 8'h00);
    chk("t7_async_halted", halted, 1'b0);
    @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
    cyc(1); chk("t7_idle_valid", instr_valid, 1'b0);
    cyc(1); expect_head("t7_restart0", 8'h00, 8'hA5);
    cyc(1); expect_head("t7_restart1", 8'h01, 8'hA4);

    cyc(2);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
